// File: rtl/maze_ctrl_pkg.sv
// Shared types and constants for the maze search controller and its
// step counter.
package maze_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    TRY   = 3'd2,
    CHECK = 3'd3,
    MOVE  = 3'd4,
    BACK  = 3'd5,
    DONE  = 3'd6,
    FAIL  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  localparam logic [7:0] GOAL_DEFAULT = 8'hFF;

endpackage

// File: rtl/maze_ctrl_step_counter.sv
// Forward-move counter: clears synchronously at search start and
// saturates at all-ones instead of wrapping.
module maze_ctrl_step_counter #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [STEP_W-1:0] count
);

  // Clear takes priority over increment; hold once all-ones is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {STEP_W{1'b0}};
    end else if (clr) begin
      count <= {STEP_W{1'b0}};
    end else if (inc && (count != {STEP_W{1'b1}})) begin
      count <= count + {{(STEP_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/maze_ctrl.sv
// Depth-first maze search controller: marks, probes, moves and backtracks
// by driving strobes into an external location/stack datapath and maze memory.
module maze_ctrl
  import maze_ctrl_pkg::*;
#(
  parameter logic [7:0] GOAL   = GOAL_DEFAULT,
  parameter int         STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        curLoc,
  input  logic              cntReach,
  input  logic              empStck,
  input  logic              mazeWall,
  output logic [1:0]        dir,
  output logic              rgLd,
  output logic              push,
  output logic              pop,
  output logic              readFromStack,
  output logic              mazeRd,
  output logic              mazeWr,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] steps
);

  state_t state;

  // The read has to carry the nxtLoc of the direction under test in the
  // same cycle, so it is decoded from the registered state and cntReach.
  assign mazeRd = (state == TRY) && !cntReach;

  maze_ctrl_step_counter #(.STEP_W(STEP_W)) stepCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) && start),
    .inc   (state == MOVE),
    .count (steps)
  );

  // Search FSM; strobes are registered and reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dir           <= UP;
      mazeWr        <= 1'b0;
      push          <= 1'b0;
      pop           <= 1'b0;
      readFromStack <= 1'b0;
      rgLd          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
    end else begin
      mazeWr        <= 1'b0;
      push          <= 1'b0;
      pop           <= 1'b0;
      readFromStack <= 1'b0;
      rgLd          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= MARK;
            mazeWr <= 1'b1;
            dir    <= UP;
          end
        end
        MARK: begin
          if (curLoc == GOAL) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= TRY;
            dir   <= UP;
          end
        end
        TRY: begin
          if (!cntReach) begin
            state <= CHECK;
          end else if (dir != DOWN) begin
            dir <= dir + 2'b01;
          end else begin
            // empStck is stable through backtrack entry, so the pop is known now
            state                       <= BACK;
            {pop, readFromStack, rgLd} <= {3{~empStck}};
          end
        end
        CHECK: begin
          if (!mazeWall) begin
            state <= MOVE;
            push  <= 1'b1;
            rgLd  <= 1'b1;
          end else if (dir != DOWN) begin
            state <= TRY;
            dir   <= dir + 2'b01;
          end else begin
            state                       <= BACK;
            {pop, readFromStack, rgLd} <= {3{~empStck}};
          end
        end
        MOVE: begin
          state  <= MARK;
          mazeWr <= 1'b1;
          dir    <= UP;
        end
        BACK: begin
          if (empStck) begin
            state <= FAIL;
            fail  <= 1'b1;
          end else begin
            state  <= MARK;
            mazeWr <= 1'b1;
            dir    <= UP;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        FAIL: begin
          if (!start) begin
            state <= IDLE;
            fail  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          dir   <= UP;
          done  <= 1'b0;
          fail  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_ctrl.sv
// Bench for maze_ctrl: behavioural datapath and maze memory, directed
// searches with hand-computed outcomes checked through a scoreboard queue.
module tb_maze_ctrl;

  typedef struct {
    logic expDone;
    logic expFail;
    int   steps;
    int   pushes;
    int   pops;
    int   rdUp;
    int   lat;
  } exp_t;

  typedef struct {
    logic [7:0] loc;
    int         walls;
    int         mode;
    logic       pulse;
    exp_t       e;
  } scen_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] curLoc;
  logic       cntReach, empStck, mazeWall;
  logic [1:0] dir;
  logic       rgLd, push, pop, readFromStack, mazeRd, mazeWr, done, fail;
  logic [7:0] steps;

  maze_ctrl #(.GOAL(8'hFF), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .curLoc(curLoc),
    .cntReach(cntReach), .empStck(empStck), .mazeWall(mazeWall),
    .dir(dir), .rgLd(rgLd), .push(push), .pop(pop),
    .readFromStack(readFromStack), .mazeRd(mazeRd), .mazeWr(mazeWr),
    .done(done), .fail(fail), .steps(steps)
  );

  always #5 clk = ~clk;

  logic       wall [256];
  logic       visited [256];
  logic [7:0] stackMem [256];
  int         sp;
  logic [7:0] nxtLoc;
  logic       rdData;
  logic       initReq = 1'b0;
  logic [7:0] initLoc = 8'h00;
  int         cyc = 0;
  int         startCyc = 0;
  logic       stimDone = 1'b0;
  int         nCmp = 0;
  int         nFail = 0;
  exp_t       expQ [$];

  // Neighbour address and grid-edge flag for the current direction
  always_comb begin
    nxtLoc   = curLoc;
    cntReach = 1'b0;
    case (dir)
      2'b00: begin cntReach = (curLoc[3:0] == 4'h0); nxtLoc = {curLoc[7:4], curLoc[3:0] - 4'h1}; end
      2'b01: begin cntReach = (curLoc[7:4] == 4'hF); nxtLoc = {curLoc[7:4] + 4'h1, curLoc[3:0]}; end
      2'b10: begin cntReach = (curLoc[7:4] == 4'h0); nxtLoc = {curLoc[7:4] - 4'h1, curLoc[3:0]}; end
      default: begin cntReach = (curLoc[3:0] == 4'hF); nxtLoc = {curLoc[7:4], curLoc[3:0] + 4'h1}; end
    endcase
  end

  assign empStck  = (sp == 0);
  assign mazeWall = rdData;

  // Datapath registers, location stack and one-cycle-latency maze memory
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (initReq) begin
      curLoc <= initLoc;
      sp     <= 0;
      rdData <= 1'b0;
      for (int i = 0; i < 256; i++) visited[i] <= 1'b0;
    end else begin
      if (mazeWr) visited[curLoc] <= 1'b1;
      rdData <= mazeRd ? (wall[nxtLoc] | visited[nxtLoc]) : 1'b0;
      if (push) stackMem[sp[7:0]] <= curLoc;
      if (rgLd) curLoc <= readFromStack ? stackMem[sp[7:0] - 8'd1] : nxtLoc;
      if (push) sp <= sp + 1;
      else if (pop) sp <= sp - 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0 open, 1 corridor along row y=F, 2 all walls, 3 path 00-10-20 only
  task automatic setWalls(input int mode);
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = a[7:0];
      case (mode)
        0: wall[a] = 1'b0;
        1: wall[a] = (v[3:0] != 4'hF);
        2: wall[a] = 1'b1;
        default: wall[a] = !((v == 8'h00) || (v == 8'h10) || (v == 8'h20));
      endcase
    end
  endtask

  task automatic initDp(input logic [7:0] loc);
    @(negedge clk);
    initLoc = loc;
    initReq = 1'b1;
    @(negedge clk);
    initReq = 1'b0;
  endtask

  task automatic runScenario(input scen_t s);
    setWalls(s.walls);
    initDp(s.loc);
    expQ.push_back(s.e);
    start    = 1'b1;
    startCyc = cyc;
    if (s.pulse) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (s.mode == 1) begin
      @(negedge clk);
      check("goal_mark_cycle1", {mazeWr, push}, 2'b10);
    end
    if (s.mode == 2) begin
      @(negedge clk);
      check("corner_mark", mazeWr, 1);
      @(negedge clk);
      check("corner_try_up_no_rd", {dir, mazeRd}, 3'b000);
      @(negedge clk);
      check("corner_try_right_rd", {dir, mazeRd}, 3'b011);
    end
    for (int i = 0; i < 4000 && !(done || fail); i++) @(negedge clk);
    check("search_finished", done | fail, 1);
    if (!s.pulse) begin
      @(negedge clk);
      check("flag_held", done | fail, 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("flag_dropped", {done, fail}, 2'b00);
  endtask

  initial begin
    fork
      begin : stim
        scen_t scens [5];
        scens[0] = '{8'hFF, 0, 1, 1'b0, '{1'b1, 1'b0, 0, 0, 0, 0, 2}};
        scens[1] = '{8'h0F, 1, 0, 1'b0, '{1'b1, 1'b0, 15, 15, 0, 15, -1}};
        scens[2] = '{8'h00, 2, 2, 1'b0, '{1'b0, 1'b1, 0, 0, 0, 0, -1}};
        scens[3] = '{8'h00, 3, 0, 1'b0, '{1'b0, 1'b1, 2, 2, 2, 0, -1}};
        scens[4] = '{8'h8F, 1, 0, 1'b1, '{1'b1, 1'b0, 7, 7, 0, 7, -1}};
        rst = 1'b1;
        #1;
        check("reset_outputs", {dir, rgLd, push, pop, readFromStack, mazeRd, mazeWr, done, fail, steps}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) runScenario(scens[k]);

        // Abort a search while in CHECK, then restart it from scratch
        setWalls(1);
        initDp(8'h0F);
        start = 1'b1;
        for (int i = 0; i < 2000 && !((steps == 8'd3) && mazeRd); i++) @(negedge clk);
        check("abort_reached_try", {steps, mazeRd}, {8'd3, 1'b1});
        @(posedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("abort_async_clear", {dir, rgLd, push, pop, readFromStack, mazeRd, mazeWr, done, fail, steps}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_release_quiet", {push, pop, mazeWr, steps}, 0);
        runScenario(scens[1]);
        stimDone = 1'b1;
      end
      begin : mon
        int   pushCnt = 0, popCnt = 0, rdUpCnt = 0;
        logic popPrev = 1'b0, flagPrev = 1'b0;
        exp_t e;
        while (!stimDone) begin
          @(negedge clk);
          if (rst) begin
            pushCnt = 0; popCnt = 0; rdUpCnt = 0;
            popPrev = 1'b0; flagPrev = 1'b0;
          end else begin
            if (push || pop) check("push_pop_exclusive", push & pop, 0);
            if (popPrev) check("mark_after_pop", {mazeWr, dir}, 3'b100);
            if (push) pushCnt++;
            if (pop) popCnt++;
            if (mazeRd && (dir == 2'b00)) rdUpCnt++;
            if ((done || fail) && !flagPrev) begin
              if (expQ.size() == 0) begin
                check("unexpected_result", 1, 0);
              end else begin
                e = expQ.pop_front();
                check("result_flags", {done, fail}, {e.expDone, e.expFail});
                check("steps", steps, e.steps);
                check("push_count", pushCnt, e.pushes);
                check("pop_count", popCnt, e.pops);
                check("up_reads", rdUpCnt, e.rdUp);
                if (e.lat >= 0) check("latency", cyc - startCyc, e.lat);
              end
              pushCnt = 0; popCnt = 0; rdUpCnt = 0;
            end
            popPrev  = pop;
            flagPrev = done || fail;
          end
        end
      end
    join
    check("leftover_expectations", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
